// File: rtl/inv_sqrt_check.sv
// Checks a 1/sqrt(x) result by forming r = x*y*y with two bit-serial multiplies
// and comparing r's bit pattern against 1.0 within a tolerance.
module inv_sqrt_check #(
    parameter logic [31:0] TOL = 32'd32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] DataIn,
    input  logic [31:0] RootIn,
    input  logic        InValid,
    output logic        InReady,
    output logic [31:0] DataOut,
    output logic        Pass,
    output logic        Invalid,
    output logic        OutValid,
    input  logic        OutReady
);

    localparam logic [31:0] ONE_F = 32'h3F800000;
    localparam logic [31:0] QNAN  = 32'h7FC00000;

    typedef enum logic [2:0] {IDLE, CHECK, MUL1, NORM1, MUL2, NORM2, DONE} state_t;

    state_t               state_q, state_d;
    logic [31:0]          x_q, y_q;
    logic [47:0]          acc_q, mcand_q;
    logic [23:0]          mplier_q;
    logic [4:0]           cnt_q;
    logic signed [9:0]    e1_q;
    logic                 bad_q;
    logic [31:0]          dout_q;
    logic                 pass_q, inv_q;

    logic                 bad_w;
    logic                 last_bit_w;
    logic signed [9:0]    er_w;
    logic [23:0]          m2_w;
    logic                 range_ok_w;

    // Zero and denormal share exp==0; Inf and NaN share exp==255.
    function automatic logic is_special(input logic [31:0] f);
        return f[31] || (f[30:23] == 8'd0) || (f[30:23] == 8'd255);
    endfunction

    // Product of two 1.x mantissas lies in [2^46, 2^48); keep the top 24 bits.
    function automatic logic [23:0] norm_mant(input logic [47:0] p);
        return p[47] ? p[47:24] : p[46:23];
    endfunction

    function automatic logic within_tol(input logic [31:0] r);
        logic [31:0] diff;
        diff = (r >= ONE_F) ? (r - ONE_F) : (ONE_F - r);
        return diff <= TOL;
    endfunction

    assign InReady  = (state_q == IDLE);
    assign OutValid = (state_q == DONE);
    assign DataOut  = dout_q;
    assign Pass     = pass_q;
    assign Invalid  = inv_q;

    assign bad_w      = is_special(x_q) || is_special(y_q);
    assign last_bit_w = (cnt_q == 5'd23);

    always_comb begin
        m2_w       = norm_mant(acc_q);
        er_w       = $signed({2'b00, x_q[30:23]}) + e1_q - 10'sd127
                     + $signed({9'd0, acc_q[47]});
        range_ok_w = (er_w >= 10'sd1) && (er_w <= 10'sd254);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (InValid) state_d = CHECK;
            // Rejected operands finish through NORM2 so the result lands one edge later.
            CHECK:   state_d = bad_w ? NORM2 : MUL1;
            MUL1:    if (last_bit_w) state_d = NORM1;
            NORM1:   state_d = MUL2;
            MUL2:    if (last_bit_w) state_d = NORM2;
            NORM2:   state_d = DONE;
            DONE:    if (OutReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control, accumulator and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            dout_q  <= '0;
            pass_q  <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                CHECK: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    bad_q <= bad_w;
                end
                MUL1, MUL2: begin
                    if (mplier_q[0])
                        acc_q <= acc_q + mcand_q;
                    cnt_q <= last_bit_w ? 5'd0 : cnt_q + 5'd1;
                end
                NORM1: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                end
                NORM2: begin
                    if (bad_q || !range_ok_w) begin
                        dout_q <= QNAN;
                        pass_q <= 1'b0;
                        inv_q  <= 1'b1;
                    end else begin
                        dout_q <= {1'b0, er_w[7:0], m2_w[22:0]};
                        pass_q <= within_tol({1'b0, er_w[7:0], m2_w[22:0]});
                        inv_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand and multiplier datapath registers
    always_ff @(posedge clk) begin
        case (state_q)
            IDLE: begin
                if (InValid) begin
                    x_q <= DataIn;
                    y_q <= RootIn;
                end
            end
            CHECK: begin
                mcand_q  <= {24'd0, 1'b1, y_q[22:0]};
                mplier_q <= {1'b1, y_q[22:0]};
            end
            MUL1, MUL2: begin
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
            NORM1: begin
                e1_q     <= $signed({1'b0, y_q[30:23], 1'b0}) - 10'sd127
                            + $signed({9'd0, acc_q[47]});
                mcand_q  <= {24'd0, 1'b1, x_q[22:0]};
                mplier_q <= norm_mant(acc_q);
            end
            default: ;
        endcase
    end

endmodule
